// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the MIPS general-purpose register file and its
// write-back decoder.
package reg_file_wb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_decoder.sv
// 5-to-32 one-hot write decoder with enable; the caller masks any bits
// that must never be written.
module wb_decoder
  import reg_file_wb_pkg::*;
(
  input  logic [REG_IDX_W-1:0] sel,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = en;
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32 x DATA_W register file: one write port fed from write-back, two
// combinational read ports; r0 reads as zero and has no storage.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  SP_INIT = 32'h0000_03FC,
  parameter bit                 BYPASS  = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [DATA_W-1:0]    wd,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [DATA_W-1:0]    rd1,
  output logic [DATA_W-1:0]    rd2
);

  logic [NUM_REGS-1:0] dec_onehot;
  logic [NUM_REGS-1:1] wen;
  logic                unused_dec_bit0;

  logic [DATA_W-1:0] regs_q  [NUM_REGS-1:1];
  logic [DATA_W-1:0] regs_d  [NUM_REGS-1:1];
  logic [DATA_W-1:0] rf_view [NUM_REGS];

  wb_decoder u_wb_decoder (
    .sel    (wa),
    .en     (we),
    .onehot (dec_onehot)
  );

  // Index 0 enable is dropped here so r0 can never be written.
  assign wen             = dec_onehot[NUM_REGS-1:1];
  assign unused_dec_bit0 = dec_onehot[REG_ZERO];

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wen[i]) regs_d[i] = wd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  // With BYPASS the incoming write data wins over the stored value.
  always_comb begin
    rd1 = rf_view[ra1];
    if (BYPASS && we && (wa == ra1) && (ra1 != REG_ZERO)) rd1 = wd;
  end

  always_comb begin
    rd2 = rf_view[ra2];
    if (BYPASS && we && (wa == ra2) && (ra2 != REG_ZERO)) rd2 = wd;
  end

endmodule
